// File: rtl/vga_timing_pkg.sv
// VGA timing package: mode record, default 640x480 mode and mode arithmetic helpers.
package vga_timing_pkg;

  localparam int CW = 10;
  localparam int TW = CW + 2;
  localparam logic [TW-1:0] TOTAL_MAX = TW'(1 << CW);

  typedef enum logic {SLOT_IDLE, SLOT_PENDING} slot_state_t;

  typedef struct packed {
    logic [CW-1:0] h_active;
    logic [CW-1:0] h_fp;
    logic [CW-1:0] h_sync;
    logic [CW-1:0] h_bp;
    logic [CW-1:0] v_active;
    logic [CW-1:0] v_fp;
    logic [CW-1:0] v_sync;
    logic [CW-1:0] v_bp;
    logic          hpol;
    logic          vpol;
  } vga_mode_t;

  localparam vga_mode_t VGA_MODE_640x480 = '{
    h_active: CW'(640), h_fp: CW'(16), h_sync: CW'(96), h_bp: CW'(48),
    v_active: CW'(480), v_fp: CW'(10), v_sync: CW'(2),  v_bp: CW'(33),
    hpol: 1'b0, vpol: 1'b0
  };

  // Totals carry two extra bits so an oversized mode cannot alias to a small one.
  function automatic logic [TW-1:0] h_total(input vga_mode_t m);
    return {2'b00, m.h_active} + {2'b00, m.h_fp} + {2'b00, m.h_sync} + {2'b00, m.h_bp};
  endfunction

  function automatic logic [TW-1:0] v_total(input vga_mode_t m);
    return {2'b00, m.v_active} + {2'b00, m.v_fp} + {2'b00, m.v_sync} + {2'b00, m.v_bp};
  endfunction

  function automatic logic mode_valid(input vga_mode_t m);
    return (m.h_active != '0) && (m.h_sync != '0) &&
           (m.v_active != '0) && (m.v_sync != '0) &&
           (h_total(m) <= TOTAL_MAX) && (v_total(m) <= TOTAL_MAX);
  endfunction

  // Sync output level at a counter position: pol inside the pulse window, ~pol outside.
  function automatic logic sync_level(input logic [CW-1:0] pos,
                                      input logic [CW-1:0] active, fp, sync,
                                      input logic pol);
    logic [TW-1:0] first;
    logic [TW-1:0] stop;
    first = {2'b00, active} + {2'b00, fp};
    stop  = first + {2'b00, sync};
    return (({2'b00, pos} >= first) && ({2'b00, pos} < stop)) ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_mode_regs.sv
// Pending/active mode registers with config handshake and validation.
//   state        | meaning
//   SLOT_IDLE    | pending slot empty, cfg_ready high, offers are validated
//   SLOT_PENDING | valid mode held, waiting for the next frame wrap to apply it
module vga_mode_regs
  import vga_timing_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      cfg_valid,
  input  vga_mode_t cfg_mode,
  input  logic      frame_wrap,
  output logic      cfg_ready,
  output vga_mode_t mode_cur,
  output vga_mode_t mode_nxt,
  output logic      cfg_applied,
  output logic      cfg_err
);

  slot_state_t state_q, state_d;
  vga_mode_t   pend_q;
  logic        take, accept, apply;

  // Next-state decode: capture offers when idle, release the slot at frame wrap.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    accept  = 1'b0;
    apply   = 1'b0;
    case (state_q)
      SLOT_IDLE: begin
        if (cfg_valid) begin
          take   = 1'b1;
          accept = mode_valid(cfg_mode);
          if (accept) state_d = SLOT_PENDING;
        end
      end
      SLOT_PENDING: begin
        if (frame_wrap) begin
          apply   = 1'b1;
          state_d = SLOT_IDLE;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  assign cfg_ready = (state_q == SLOT_IDLE);
  // The counter decode looks at the mode that will be active after this edge.
  assign mode_nxt  = apply ? pend_q : mode_cur;

  // State, mode registers and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SLOT_IDLE;
      pend_q      <= VGA_MODE_640x480;
      mode_cur    <= VGA_MODE_640x480;
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_applied <= apply;
      cfg_err     <= take && !accept;
      if (accept) pend_q   <= cfg_mode;
      if (apply)  mode_cur <= pend_q;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel/line counters, sync and display-enable decode, markers.
module vga_timing_ctrl
  import vga_timing_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_active,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic          cfg_applied,
  output logic          cfg_err
);

  vga_mode_t     cfg_mode, mode_cur, mode_nxt;
  logic          x_last, y_last, frame_wrap;
  logic [CW-1:0] x_n, y_n;
  logic          de_n, hs_n, vs_n;

  assign cfg_mode = '{
    h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
    hpol: cfg_hpol, vpol: cfg_vpol
  };

  vga_mode_regs u_mode_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_mode    (cfg_mode),
    .frame_wrap  (frame_wrap),
    .cfg_ready   (cfg_ready),
    .mode_cur    (mode_cur),
    .mode_nxt    (mode_nxt),
    .cfg_applied (cfg_applied),
    .cfg_err     (cfg_err)
  );

  assign x_last     = ({2'b00, x} == h_total(mode_cur) - TW'(1));
  assign y_last     = ({2'b00, y} == v_total(mode_cur) - TW'(1));
  assign frame_wrap = pix_en && x_last && y_last;

  // Next counter position and the decode of that position, so outputs stay aligned with x/y.
  always_comb begin
    x_n = x_last ? '0 : x + 1'b1;
    y_n = y;
    if (x_last) y_n = y_last ? '0 : y + 1'b1;
    de_n = (x_n < mode_nxt.h_active) && (y_n < mode_nxt.v_active);
    hs_n = sync_level(x_n, mode_nxt.h_active, mode_nxt.h_fp, mode_nxt.h_sync, mode_nxt.hpol);
    vs_n = sync_level(y_n, mode_nxt.v_active, mode_nxt.v_fp, mode_nxt.v_sync, mode_nxt.vpol);
  end

  // Counters, registered decode and line/frame markers advance only on pixel strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b1;
      hsync       <= ~VGA_MODE_640x480.hpol;
      vsync       <= ~VGA_MODE_640x480.vpol;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        x           <= x_n;
        y           <= y_n;
        de          <= de_n;
        hsync       <= hs_n;
        vsync       <= vs_n;
        line_start  <= x_last;
        frame_start <= x_last && y_last;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl: default-mode frame, mode swap, rejection,
// frame-wrap handshake and asynchronous reset.
module tb_vga_timing_ctrl;
  import vga_timing_pkg::*;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp;
  } mode_in_t;

  // n = strobe index since the table run started; remaining fields are expected outputs
  typedef struct {
    int n, x, y, de, hs, vs, ls, fs, app;
  } vec_t;

  typedef struct {
    mode_in_t m;
    int       err;
  } cfg_vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_h_active = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
  logic [CW-1:0] cfg_v_active = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
  logic          cfg_hpol = 1'b0, cfg_vpol = 1'b0;
  logic [CW-1:0] x, y;
  logic          de, hsync, vsync, line_start, frame_start, cfg_applied, cfg_err;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  vga_timing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .cfg_applied(cfg_applied), .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input mode_in_t m);
    cfg_h_active = CW'(m.ha); cfg_h_fp = CW'(m.hf); cfg_h_sync = CW'(m.hs); cfg_h_bp = CW'(m.hb);
    cfg_v_active = CW'(m.va); cfg_v_fp = CW'(m.vf); cfg_v_sync = CW'(m.vs); cfg_v_bp = CW'(m.vb);
    cfg_hpol = 1'(m.hp); cfg_vpol = 1'(m.vp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_de"}, int'(de), 1);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_line_start"}, int'(line_start), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_cfg_applied"}, int'(cfg_applied), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Strobe n_max pixels with `gap` idle clocks before each strobe, checking vq rows and holds.
  task automatic run_vectors(input string tag, input int n_max, input int gap, output int fs_cyc);
    int            cyc;
    int            hold_bad;
    logic [CW-1:0] sx;
    cyc      = 0;
    hold_bad = 0;
    fs_cyc   = -1;
    sx       = x;
    for (int n = 1; n <= n_max; n++) begin
      pix_en = 1'b0;
      for (int j = 0; j < gap; j++) begin
        tick();
        cyc++;
        if (x != sx || line_start || frame_start || cfg_applied) hold_bad++;
      end
      pix_en = 1'b1;
      tick();
      cyc++;
      pix_en = 1'b0;
      sx = x;
      if (frame_start && fs_cyc < 0) fs_cyc = cyc;
      foreach (vq[i]) begin
        if (vq[i].n == n) begin
          chk($sformatf("%s_n%0d_x", tag, n), int'(x), vq[i].x);
          chk($sformatf("%s_n%0d_y", tag, n), int'(y), vq[i].y);
          chk($sformatf("%s_n%0d_de", tag, n), int'(de), vq[i].de);
          chk($sformatf("%s_n%0d_hsync", tag, n), int'(hsync), vq[i].hs);
          chk($sformatf("%s_n%0d_vsync", tag, n), int'(vsync), vq[i].vs);
          chk($sformatf("%s_n%0d_line_start", tag, n), int'(line_start), vq[i].ls);
          chk($sformatf("%s_n%0d_frame_start", tag, n), int'(frame_start), vq[i].fs);
          chk($sformatf("%s_n%0d_cfg_applied", tag, n), int'(cfg_applied), vq[i].app);
        end
      end
    end
    if (gap > 0) chk({tag, "_hold_between_strobes"}, hold_bad, 0);
  endtask

  initial begin
    mode_in_t m1, m2;
    cfg_vec_t cv[$];
    int seq_bad, de_cnt, hs_lo, hs_line0, hs_first, vs_lo, vs_ymin, vs_ymax;
    int ls_cnt, fs_cnt, fs_k, app_cnt, app_k, ex, ey, fs_cyc, cnt;
    logic fs_seen;

    m1 = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0};
    m2 = '{1000, 10, 10, 4, 1, 0, 1, 0, 0, 1};

    // Power-on reset values
    #12;
    chk_reset("por");

    // Run default mode to (300,200) with m1 pending, then reset asynchronously
    release_rst();
    set_cfg(m1);
    pix_en = 1'b1;
    for (int k = 1; k <= 160300; k++) begin
      cfg_valid = (k == 10);
      tick();
      if (k == 10) chk("a1_cfg_ready_fall", int'(cfg_ready), 0);
    end
    cfg_valid = 1'b0;
    chk("a1_x_at_reset", int'(x), 300);
    chk("a1_y_at_reset", int'(y), 200);
    chk("a1_pending_ready", int'(cfg_ready), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_reset");

    // Full default frame after reset; m1 offered mid-frame and applied at the wrap
    release_rst();
    pix_en = 1'b1;
    seq_bad = 0; de_cnt = int'(de); hs_lo = int'(!hsync); hs_line0 = int'(!hsync);
    hs_first = hsync ? -1 : 0; vs_lo = int'(!vsync); vs_ymin = 9999; vs_ymax = -1;
    ls_cnt = 0; fs_cnt = 0; fs_k = -1; app_cnt = 0; app_k = -1;
    if (x != 0 || y != 0) seq_bad++;
    for (int k = 1; k <= 420000; k++) begin
      cfg_valid = (k == 80000);
      tick();
      if (k == 80000) chk("a2_cfg_ready_fall", int'(cfg_ready), 0);
      if (k < 420000) begin
        ex = k % 800;
        ey = k / 800;
        if (int'(x) != ex || int'(y) != ey) seq_bad++;
        if (de != ((ex < 640) && (ey < 480))) seq_bad++;
        if (hsync != !((ex >= 656) && (ex < 752))) seq_bad++;
        if (vsync != !((ey == 490) || (ey == 491))) seq_bad++;
        if (de) de_cnt++;
        if (!hsync) begin
          hs_lo++;
          if (y == 0) hs_line0++;
          if (y == 0 && hs_first < 0) hs_first = int'(x);
        end
        if (!vsync) begin
          vs_lo++;
          if (int'(y) < vs_ymin) vs_ymin = int'(y);
          if (int'(y) > vs_ymax) vs_ymax = int'(y);
        end
      end
      if (line_start) ls_cnt++;
      if (frame_start) begin fs_cnt++; fs_k = k; end
      if (cfg_applied) begin app_cnt++; app_k = k; end
    end
    cfg_valid = 1'b0;
    chk("a2_xy_decode_sequence", seq_bad, 0);
    chk("a2_de_count", de_cnt, 640 * 480);
    chk("a2_hsync_low_total", hs_lo, 96 * 525);
    chk("a2_hsync_low_line0", hs_line0, 96);
    chk("a2_hsync_first_x", hs_first, 656);
    chk("a2_vsync_low_total", vs_lo, 2 * 800);
    chk("a2_vsync_first_line", vs_ymin, 490);
    chk("a2_vsync_last_line", vs_ymax, 491);
    chk("a2_line_start_count", ls_cnt, 525);
    chk("a2_frame_start_count", fs_cnt, 1);
    chk("a2_frame_start_clk", fs_k, 420000);
    chk("a2_cfg_applied_count", app_cnt, 1);
    chk("a2_cfg_applied_clk", app_k, 420000);
    chk("a2_wrap_line_start", int'(line_start), 1);
    chk("a2_wrap_x", int'(x), 0);
    chk("a2_wrap_y", int'(y), 0);
    chk("a2_wrap_hsync_m1_idle", int'(hsync), 0);
    chk("a2_wrap_vsync_m1_idle", int'(vsync), 1);
    chk("a2_cfg_ready_back", int'(cfg_ready), 1);

    // m1 frame with a strobe every 4th clk
    vq.delete();
    vq.push_back('{1, 1, 0, 1, 0, 1, 0, 0, 0});
    vq.push_back('{7, 7, 0, 1, 0, 1, 0, 0, 0});
    vq.push_back('{8, 8, 0, 0, 0, 1, 0, 0, 0});
    vq.push_back('{9, 9, 0, 0, 0, 1, 0, 0, 0});
    vq.push_back('{10, 10, 0, 0, 1, 1, 0, 0, 0});
    vq.push_back('{11, 11, 0, 0, 1, 1, 0, 0, 0});
    vq.push_back('{12, 12, 0, 0, 0, 1, 0, 0, 0});
    vq.push_back('{13, 13, 0, 0, 0, 1, 0, 0, 0});
    vq.push_back('{14, 0, 1, 1, 0, 1, 1, 0, 0});
    vq.push_back('{55, 13, 3, 0, 0, 1, 0, 0, 0});
    vq.push_back('{56, 0, 4, 0, 0, 1, 1, 0, 0});
    vq.push_back('{61, 5, 4, 0, 0, 1, 0, 0, 0});
    vq.push_back('{70, 0, 5, 0, 0, 0, 1, 0, 0});
    vq.push_back('{81, 11, 5, 0, 1, 0, 0, 0, 0});
    vq.push_back('{84, 0, 6, 0, 0, 1, 1, 0, 0});
    vq.push_back('{98, 0, 0, 1, 0, 1, 1, 1, 0});
    vq.push_back('{99, 1, 0, 1, 0, 1, 0, 0, 0});
    run_vectors("m1", 99, 3, fs_cyc);
    chk("m1_frame_start_period_clk", fs_cyc, 98 * 4);

    // Rejected offers: pulse cfg_err, keep the slot empty, leave counters alone
    cv.push_back('{'{8, 2, 0, 2, 4, 1, 1, 1, 1, 0}, 1});
    cv.push_back('{'{0, 2, 2, 2, 4, 1, 1, 1, 1, 0}, 1});
    cv.push_back('{'{8, 2, 2, 2, 0, 1, 1, 1, 1, 0}, 1});
    cv.push_back('{'{8, 2, 2, 2, 4, 1, 0, 1, 1, 0}, 1});
    cv.push_back('{'{1000, 10, 10, 5, 4, 1, 1, 1, 1, 0}, 1});
    cv.push_back('{'{8, 2, 2, 2, 1000, 10, 10, 5, 1, 0}, 1});
    foreach (cv[i]) begin
      set_cfg(cv[i].m);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk($sformatf("cfg%0d_err_pulse", i), int'(cfg_err), cv[i].err);
      chk($sformatf("cfg%0d_ready", i), int'(cfg_ready), 1);
      tick();
      chk($sformatf("cfg%0d_err_single", i), int'(cfg_err), 0);
      chk($sformatf("cfg%0d_x_hold", i), int'(x), 1);
    end

    // m1 still in force: from (1,0) the last pixel (13,6) is 96 strobes away
    pix_en = 1'b1;
    cnt = 0;
    while (!(x == 13 && y == 6) && cnt < 200) begin tick(); cnt++; end
    chk("e_m1_kept_strobes", cnt, 96);

    // Offer m2 on the frame-wrap edge itself: captured, but not applied this wrap
    set_cfg(m2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("e_wrap_frame_start", int'(frame_start), 1);
    chk("e_wrap_not_applied", int'(cfg_applied), 0);
    chk("e_wrap_captured", int'(cfg_ready), 0);
    chk("e_wrap_no_err", int'(cfg_err), 0);
    chk("e_wrap_x", int'(x), 0);
    chk("e_wrap_y", int'(y), 0);
    cnt = 0;
    fs_seen = 1'b0;
    while (!fs_seen && cnt < 200) begin
      tick();
      cnt++;
      if (cnt == 14) chk("e_m1_line_len", int'(y) * 100 + int'(x), 100);
      fs_seen = frame_start;
    end
    chk("e_m1_frame_len", cnt, 98);
    chk("e_m2_applied", int'(cfg_applied), 1);
    chk("e_m2_hsync_idle", int'(hsync), 1);
    chk("e_m2_vsync_idle", int'(vsync), 0);
    chk("e_m2_de", int'(de), 1);
    chk("e_m2_ready", int'(cfg_ready), 1);

    // m2 frame: 1024-pixel lines (maximum total), two lines, sync active-high vertically
    vq.delete();
    vq.push_back('{1, 1, 0, 1, 1, 0, 0, 0, 0});
    vq.push_back('{999, 999, 0, 1, 1, 0, 0, 0, 0});
    vq.push_back('{1000, 1000, 0, 0, 1, 0, 0, 0, 0});
    vq.push_back('{1009, 1009, 0, 0, 1, 0, 0, 0, 0});
    vq.push_back('{1010, 1010, 0, 0, 0, 0, 0, 0, 0});
    vq.push_back('{1019, 1019, 0, 0, 0, 0, 0, 0, 0});
    vq.push_back('{1020, 1020, 0, 0, 1, 0, 0, 0, 0});
    vq.push_back('{1023, 1023, 0, 0, 1, 0, 0, 0, 0});
    vq.push_back('{1024, 0, 1, 0, 1, 1, 1, 0, 0});
    vq.push_back('{2047, 1023, 1, 0, 1, 1, 0, 0, 0});
    vq.push_back('{2048, 0, 0, 1, 1, 0, 1, 1, 0});
    run_vectors("m2", 2048, 0, fs_cyc);
    chk("m2_frame_start_period_clk", fs_cyc, 2048);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
